// File: rtl/emergency_preempt_ctrl.sv
// Emergency preemption producer for the TLC emergency[3:0] input.
// Optional HOLD conflict monitor: define PREEMPT_CONFLICT_MON_EN.
module emergency_preempt_ctrl #(
  parameter int DEBOUNCE_CYC  = 4,
  parameter int HOLD_CYC      = 32,
  parameter int MAX_HOLD_CYC  = 64,
  parameter int GREEN_TIMEOUT = 64,
  parameter int CLR_CYC       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_raw,
  input  logic [1:0] North_r,
  input  logic [1:0] East_r,
  input  logic [1:0] South_r,
  input  logic [1:0] West_r,
  output logic [3:0] emergency,
  output logic [3:0] ack,
  output logic       busy,
  output logic       timeout_err,
  output logic       conflict_err
);

  localparam int CM1 =
    (GREEN_TIMEOUT > MAX_HOLD_CYC) ? GREEN_TIMEOUT : MAX_HOLD_CYC;
  localparam int CMAX = (CM1 > CLR_CYC) ? CM1 : CLR_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      gnt, gnt_n;
  logic [1:0]      ptr, ptr_n;
  logic [3:0]      em_n;
  logic [3:0]      ack_n;
  logic            to_n;
  logic [3:0]      req_db;
  logic [DW-1:0]   db_cnt [4];
  logic [1:0]      pick;
  logic            pick_vld;
  logic [3:0][1:0] lt;
  logic            g_green;

  assign lt      = {West_r, South_r, East_r, North_r};
  assign g_green = (lt[gnt] == 2'b10);

  // Per-direction debounce: flip req_db after DEBOUNCE_CYC
  // consecutive samples disagreeing with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_db <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_raw[i] != req_db[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            req_db[i] <= ~req_db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Round-robin pick: first debounced request at or after ptr.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!pick_vld && req_db[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    gnt_n   = gnt;
    ptr_n   = ptr;
    em_n    = emergency;
    ack_n   = '0;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (pick_vld) begin
          state_n = ASSERT;
          gnt_n   = pick;
          em_n    = 4'b0001 << pick;
          ptr_n   = pick + 2'd1;
        end
      end
      ASSERT: begin
        if (g_green) begin
          ack_n   = 4'b0001 << gnt;
          state_n = HOLD;
          cnt_n   = '0;
        end else if (cnt == CW'(GREEN_TIMEOUT - 1)) begin
          to_n    = 1'b1;
          em_n    = '0;
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if ((int'(cnt) >= HOLD_CYC - 1 && !req_db[gnt]) ||
            cnt == CW'(MAX_HOLD_CYC - 1)) begin
          em_n    = '0;
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        // The IDLE arbitration cycle closes the all-clear gap,
        // so the whole zero gap is exactly CLR_CYC cycles.
        if (int'(cnt) >= CLR_CYC - 2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        em_n    = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt         <= '0;
      ptr         <= '0;
      emergency   <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gnt         <= gnt_n;
      ptr         <= ptr_n;
      emergency   <= em_n;
      ack         <= ack_n;
      timeout_err <= to_n;
      busy        <= (state_n != IDLE);
    end
  end

`ifdef PREEMPT_CONFLICT_MON_EN
  logic others_lit;

  // Any non-granted direction showing green or yellow.
  always_comb begin
    others_lit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) != gnt &&
          (lt[k] == 2'b10 || lt[k] == 2'b01))
        others_lit = 1'b1;
    end
  end

  // Sticky conflict flag, armed only during HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      conflict_err <= 1'b0;
    else if (state == HOLD && others_lit)
      conflict_err <= 1'b1;
  end
`else
  assign conflict_err = 1'b0;
`endif

endmodule

// File: doc/emergency_preempt_ctrl.md
Name: emergency_preempt_ctrl

Overview:
- Producer side of the TLC `emergency[3:0]` input.
- Debounces raw per-direction emergency-vehicle requests and arbitrates them round-robin.
- Drives a one-hot `emergency` vector into TLC, observes the TLC light outputs, and acknowledges when the granted direction turns green.
- Enforces hold and clearance times, and flags a timeout if TLC never serves the request.

Parameters:
- DEBOUNCE_CYC, 4, consecutive samples required to set or clear a debounced request.
- HOLD_CYC, 32, minimum cycles emergency stays asserted after green is observed.
- MAX_HOLD_CYC, 64, cap on hold length while the request persists (must be >= HOLD_CYC).
- GREEN_TIMEOUT, 64, cycles allowed from emergency assertion to observed green.
- CLR_CYC, 8, all-clear gap after release before the next grant.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- req_raw  in  4  raw requests; bit0=North, bit1=East, bit2=South, bit3=West.
- North_r  in  2  TLC North light; encoding 00=red, 01=yellow, 10=green, 11=invalid.
- East_r  in  2  TLC East light, same encoding.
- South_r  in  2  TLC South light, same encoding.
- West_r  in  2  TLC West light, same encoding.
- emergency  out  4  one-hot or zero preemption vector to TLC, same bit map as req_raw.
- ack  out  4  one-cycle pulse on the bit whose green was observed.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when GREEN_TIMEOUT expires.
- conflict_err  out  1  see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - emergency, ack, busy, timeout_err and conflict_err are all 0.
  - Debounce counters and req_db are 0, state is IDLE, round-robin pointer is 0 (North highest priority).
- Debounce, per bit:
  - A counter increments while req_raw[i] differs from req_db[i] and resets to 0 when they match.
  - req_db[i] toggles on the edge where the counter reaches DEBOUNCE_CYC.
  - Glitches shorter than DEBOUNCE_CYC cycles have no effect.
- All outputs are registered. No combinational path from inputs to outputs.
- State machine, states IDLE / ASSERT / HOLD / RELEASE:
  - IDLE: if any req_db bit is set, grant the first set bit at or after the pointer, wrapping 3->0. On the next edge, emergency = one-hot(g), go to ASSERT, wait counter = 0. The pointer becomes g+1 mod 4.
  - ASSERT: wait counter increments each cycle.
    - If the light of g == 10, pulse ack[g] for 1 cycle, go to HOLD, hold counter = 0.
    - Else if the wait counter reaches GREEN_TIMEOUT-1, pulse timeout_err, emergency = 0, go to RELEASE.
    - If green and timeout occur in the same cycle, green wins.
  - HOLD: hold counter increments. Exit when the counter >= HOLD_CYC-1 and req_db[g]==0, or when the counter reaches MAX_HOLD_CYC-1. On exit, emergency = 0 and go to RELEASE.
  - RELEASE: count CLR_CYC cycles with emergency = 0, then go to IDLE. New requests are only latched in req_db during this time, not granted.
- Requests from other directions never preempt the current grant. They are served in later rounds in round-robin order.
- If req_db[g] drops during ASSERT, the grant is kept until green or timeout.
- Invalid light code 11 is treated as not green.
- emergency never has more than one bit set.
- If reset is asserted mid-operation, emergency drops to 0 immediately (asynchronously).
- After reset releases, the block restarts in IDLE and must re-debounce all requests.

Optional Feature:
- Macro: PREEMPT_CONFLICT_MON_EN.
- When defined, during HOLD conflict_err is set if any non-granted direction shows 10 (green) or 01 (yellow).
  - The flag is registered and sticky until reset.
  - The HOLD sequencing is otherwise unchanged.
- When undefined, conflict_err is tied to 0 and no monitor logic is built.

Test Plan:
1. Reset and glitch:
   - Stimulus: hold rst=0 for 5 cycles, release it, then pulse req_raw=0001 for 3 cycles.
   - Required: emergency stays 0000 and busy stays 0.
2. Basic North preemption (defaults):
   - Stimulus: req_raw=0001 held; model TLC drives North_r=10 three cycles after emergency rises; release req_raw 10 cycles later.
   - Required: emergency=0001 starting 5 edges after the first high sample. ack=0001 for exactly 1 cycle. emergency held for 32 cycles after green, then 0000 for 8 cycles.
3. Round-robin:
   - Stimulus: req_raw=0101 held continuously.
   - Required: grant order North (0001), then South (0100), then North, alternating, with an 8-cycle all-zero gap between grants.
4. Timeout:
   - Stimulus: req_raw=0010 while East_r stays 00.
   - Required: emergency=0010 for 64 cycles, a single-cycle timeout_err, no ack, then RELEASE.
5. Hold extension:
   - Stimulus: South granted and green, req_raw[2] kept high.
   - Required: emergency drops after exactly 64 cycles of HOLD.
6. Conflict with PREEMPT_CONFLICT_MON_EN defined:
   - Stimulus: during a North HOLD, drive East_r=10 for 1 cycle.
   - Required: conflict_err=1 from the next edge and stays high until reset.
   - With the macro undefined, the same stimulus leaves conflict_err=0.
